// File: rtl/jetson_link_pkg.sv
// Shared definitions for the Jetson SPI link: opcode constants, word field
// widths, dispatcher FSM state encoding and small word-building helpers.
// Used by the core-side dispatcher and the SPI-side logic.
package jetson_link_pkg;

    localparam int WORD_W   = 32;
    localparam int OP_W     = 4;
    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 24;
    localparam int STATUS_W = 13;

    localparam logic [OP_W-1:0] OP_STATUS = 4'h0;
    localparam logic [OP_W-1:0] OP_WRITE  = 4'h1;
    localparam logic [OP_W-1:0] OP_READ   = 4'h2;
    localparam logic [OP_W-1:0] OP_ECHO   = 4'h3;
    localparam logic [OP_W-1:0] OP_ERR    = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXEC    = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_REPLY   = 3'd3,
        ST_STATUS  = 3'd4
    } disp_state_t;

    // Status words carry opcode 0 and the live status in the low bits.
    function automatic logic [WORD_W-1:0] status_word(input logic [STATUS_W-1:0] s);
        return {OP_STATUS, 15'b0, s};
    endfunction

    // Opcodes that count as host traffic for the watchdog.
    function automatic logic is_valid_op(input logic [OP_W-1:0] op);
        return (op == OP_WRITE) || (op == OP_READ) || (op == OP_ECHO);
    endfunction

endpackage

// File: rtl/jetson_wdt.sv
// Watchdog: counts cycles since the last clear and raises a sticky flag once
// CYCLES-1 is reached. The count holds there (no wrap) until cleared.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - restart the count and drop the flag
//   expired   - sticky expiry flag
module jetson_wdt
    import jetson_link_pkg::*;
#(
    parameter int unsigned CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic expired
);

    localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            expired <= 1'b0;
        end else if (clear) begin
            cnt     <= '0;
            expired <= 1'b0;
        end else if (cnt == LAST) begin
            expired <= 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/jetson_cmd_dispatch.sv
// Core-side command dispatcher for the Jetson SPI link. Pops command words
// from the SPI->core FIFO, drives a simple register bus, and pushes replies
// and status words into the core->SPI FIFO. A watchdog flags loss of host
// traffic.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   rd_rdy, rd_dout, rd_en   - SPI->core FWFT FIFO (head word, pop)
//   wr_en, wr_din, tx_full   - core->SPI FIFO push side (tx_full = prog_full)
//   reg_addr/wdata/we/re     - register bus outputs; reg_rdata read data
//   status_in                - live core status, sent in status words
//   wdt_expired              - no valid command for WDT_CYCLES cycles
//   err_cnt                  - saturating count of bad opcodes
//
// FIFO handshake: the head word is consumed on a clock edge where rd_en and
// rd_rdy are both high; rd_en is only raised after rd_rdy was seen in IDLE,
// so the word latched in IDLE is the one popped during EXEC. wr_en pushes one
// word per high cycle and is only raised after tx_full was seen low.
module jetson_cmd_dispatch
    import jetson_link_pkg::*;
#(
    parameter int unsigned WDT_CYCLES    = 50_000_000,
    parameter int unsigned STATUS_PERIOD = 1_000_000,
    parameter int unsigned REG_RD_LAT    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_rdy,
    input  logic [WORD_W-1:0]   rd_dout,
    output logic                rd_en,
    output logic                wr_en,
    output logic [WORD_W-1:0]   wr_din,
    input  logic                tx_full,
    output logic [ADDR_W-1:0]   reg_addr,
    output logic [DATA_W-1:0]   reg_wdata,
    output logic                reg_we,
    output logic                reg_re,
    input  logic [DATA_W-1:0]   reg_rdata,
    input  logic [STATUS_W-1:0] status_in,
    output logic                wdt_expired,
    output logic [7:0]          err_cnt
);

    localparam logic [2:0] RD_LAT = 3'(REG_RD_LAT);

    disp_state_t         state;
    logic [WORD_W-1:0]   cmd;
    logic [WORD_W-1:0]   reply;
    logic [2:0]          rd_cnt;
    logic [STATUS_W-1:0] last_status;
    logic                status_pend;
    logic [31:0]         per_cnt;

    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              status_sent;
    logic              period_hit;
    logic              wdt_clear;

    assign op = cmd[31:28];
    assign a  = cmd[27:24];
    assign d  = cmd[23:0];

    assign status_sent = (state == ST_STATUS) && !tx_full;
    assign period_hit  = (STATUS_PERIOD != 0) && (per_cnt == 32'(STATUS_PERIOD - 1));
    // The word is popped during EXEC, so that is where host traffic is counted.
    assign wdt_clear   = (state == ST_EXEC) && is_valid_op(op);

    jetson_wdt #(.CYCLES(WDT_CYCLES)) u_wdt (
        .clk     (clk),
        .rst     (rst),
        .clear   (wdt_clear),
        .expired (wdt_expired)
    );

    // Forced-resend timer; holds at the hit value until a status word goes out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt <= '0;
        end else if (status_sent) begin
            per_cnt <= '0;
        end else if ((STATUS_PERIOD != 0) && !period_hit) begin
            per_cnt <= per_cnt + 32'd1;
        end
    end

    // Pending starts set so one status word follows every reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_pend <= 1'b1;
            last_status <= '0;
        end else if (status_sent) begin
            status_pend <= 1'b0;
            last_status <= status_in;
        end else if ((status_in != last_status) || period_hit) begin
            status_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cmd       <= '0;
            reply     <= '0;
            rd_cnt    <= '0;
            rd_en     <= 1'b0;
            wr_en     <= 1'b0;
            wr_din    <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            err_cnt   <= '0;
        end else begin
            rd_en  <= 1'b0;
            wr_en  <= 1'b0;
            reg_we <= 1'b0;
            reg_re <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (status_pend && !tx_full) begin
                        state <= ST_STATUS;
                    end else if (rd_rdy) begin
                        rd_en <= 1'b1;
                        cmd   <= rd_dout;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (op)
                        OP_WRITE: begin
                            reg_addr  <= a;
                            reg_wdata <= d;
                            reg_we    <= 1'b1;
                            state     <= ST_IDLE;
                        end
                        OP_READ: begin
                            reg_addr <= a;
                            reg_re   <= 1'b1;
                            rd_cnt   <= '0;
                            state    <= ST_RD_WAIT;
                        end
                        OP_ECHO: begin
                            reply <= cmd;
                            state <= ST_REPLY;
                        end
                        default: begin
                            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                            reply <= {OP_ERR, a, d};
                            state <= ST_REPLY;
                        end
                    endcase
                end
                ST_RD_WAIT: begin
                    // rd_cnt is 0 in the cycle reg_re is high, so data is valid at RD_LAT.
                    if (rd_cnt == RD_LAT) begin
                        reply <= {OP_READ, a, reg_rdata};
                        state <= ST_REPLY;
                    end else begin
                        rd_cnt <= rd_cnt + 3'd1;
                    end
                end
                ST_REPLY: begin
                    if (!tx_full) begin
                        wr_en  <= 1'b1;
                        wr_din <= reply;
                        state  <= ST_IDLE;
                    end
                end
                ST_STATUS: begin
                    if (!tx_full) begin
                        wr_en  <= 1'b1;
                        wr_din <= status_word(status_in);
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jetson_cmd_dispatch.sv
// Directed testbench for jetson_cmd_dispatch: FWFT input FIFO model, output
// and register-bus monitors, and a register slave with fixed read latency.
module tb_jetson_cmd_dispatch;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_rdy = 1'b0;
    logic [31:0] rd_dout = 32'h0;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] wr_din;
    logic        tx_full;
    logic [3:0]  reg_addr;
    logic [23:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [23:0] reg_rdata;
    logic [12:0] status_in;
    logic        wdt_expired;
    logic [7:0]  err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] in_q[$];
    logic [31:0] out_q[$];
    logic [27:0] we_q[$];
    logic [31:0] exp_q[$];
    int          pop_cnt = 0;
    int          re_cnt  = 0;

    logic [23:0] mem [16];
    logic        rd_pipe [LAT];
    logic [3:0]  addr_pipe [LAT];

    always #5 clk = ~clk;

    jetson_cmd_dispatch #(
        .WDT_CYCLES    (100),
        .STATUS_PERIOD (0),
        .REG_RD_LAT    (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_rdy      (rd_rdy),
        .rd_dout     (rd_dout),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .wr_din      (wr_din),
        .tx_full     (tx_full),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_we      (reg_we),
        .reg_re      (reg_re),
        .reg_rdata   (reg_rdata),
        .status_in   (status_in),
        .wdt_expired (wdt_expired),
        .err_cnt     (err_cnt)
    );

    // SPI->core FIFO model: pop on rd_en, refresh head after the negedge.
    always @(posedge clk) begin
        if (rd_en) begin
            if (in_q.size() > 0) void'(in_q.pop_front());
            pop_cnt++;
        end
    end

    always @(negedge clk) begin
        #2;
        rd_rdy  = (in_q.size() > 0);
        rd_dout = (in_q.size() > 0) ? in_q[0] : 32'h0;
    end

    // Output monitors and register slave; read data only valid LAT cycles after reg_re.
    always @(posedge clk) begin
        if (wr_en) out_q.push_back(wr_din);
        if (reg_we) begin
            we_q.push_back({reg_addr, reg_wdata});
            mem[reg_addr] <= reg_wdata;
        end
        if (reg_re) re_cnt++;
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                rd_pipe[i]   <= 1'b0;
                addr_pipe[i] <= 4'h0;
            end
        end else begin
            rd_pipe[0]   <= reg_re;
            addr_pipe[0] <= reg_addr;
            for (int i = 1; i < LAT; i++) begin
                rd_pipe[i]   <= rd_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
        end
    end

    assign reg_rdata = rd_pipe[LAT-1] ? mem[addr_pipe[LAT-1]] : 24'hBADBAD;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [31:0] w);
        @(negedge clk);
        in_q.push_back(w);
    endtask

    task automatic wait_out(input int n, input int budget, input string tag);
        int c = 0;
        while (out_q.size() < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        check(tag, 32'(out_q.size() >= n), 32'd1);
    endtask

    // Returns at the negedge of the cycle where rd_en is high (the EXEC cycle).
    task automatic wait_rd_en(input int budget, input string tag);
        int c = 0;
        @(negedge clk);
        while (!rd_en && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(tag, 32'(rd_en), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int base;
        logic [31:0] w;

        // Reset state
        rst       = 1'b1;
        tx_full   = 1'b0;
        status_in = 13'h0ABC;
        tick(3);
        check("rst_wr_en",   32'(wr_en),       32'd0);
        check("rst_rd_en",   32'(rd_en),       32'd0);
        check("rst_reg_we",  32'(reg_we),      32'd0);
        check("rst_reg_re",  32'(reg_re),      32'd0);
        check("rst_wdt",     32'(wdt_expired), 32'd0);
        check("rst_err_cnt", 32'(err_cnt),     32'd0);
        check("rst_wr_din",  wr_din,           32'h0);
        @(negedge clk);
        rst = 1'b0;

        // One status word after reset, then quiet
        wait_out(1, 20, "status_after_reset_timeout");
        check("status_after_reset", out_q[0], 32'h0000_0ABC);
        tick(8);
        check("single_status_word", 32'(out_q.size()), 32'd1);

        // WRITE
        push_cmd(32'h15AB_CDEF);
        tick(10);
        check("write_strobe_count", 32'(we_q.size()), 32'd1);
        check("write_addr_data",    {4'h0, we_q[0]},  32'h05AB_CDEF);
        check("write_no_reply",     32'(out_q.size()), 32'd1);

        // READ with latency 2 after preloading addr 3
        push_cmd(32'h1312_3456);
        push_cmd(32'h2300_0000);
        wait_out(2, 40, "read_reply_timeout");
        check("read_reply", out_q[1], 32'h2312_3456);
        tick(10);
        check("read_reply_once", 32'(out_q.size()), 32'd2);
        check("read_strobe_once", 32'(re_cnt), 32'd1);

        // ECHO held by tx_full, next command must stay queued
        @(negedge clk);
        tx_full = 1'b1;
        push_cmd(32'h3DEA_DBEE);
        push_cmd(32'h3000_0001);
        tick(4);
        check("echo_popped", 32'(pop_cnt), 32'd4);
        tick(10);
        check("hold_no_pop",     32'(pop_cnt),      32'd4);
        check("hold_no_push",    32'(out_q.size()), 32'd2);
        check("hold_next_queued", 32'(in_q.size()), 32'd1);
        @(negedge clk);
        tx_full = 1'b0;
        wait_out(4, 40, "echo_release_timeout");
        check("echo_reply",  out_q[2], 32'h3DEA_DBEE);
        check("echo_next",   out_q[3], 32'h3000_0001);
        check("echo_popped_after", 32'(pop_cnt), 32'd5);

        // Bad opcodes: counting, then saturation
        for (int i = 0; i < 300; i++) begin
            w = {4'h7, 28'(i * 32'h0012345)};
            exp_q.push_back({4'hF, w[27:0]});
            push_cmd(w);
            if (i == 4) begin
                wait_out(9, 60, "bad_first5_timeout");
                check("err_cnt_5", 32'(err_cnt), 32'd5);
            end
        end
        wait_out(304, 1500, "bad_all_timeout");
        check("err_cnt_saturated", 32'(err_cnt), 32'd255);
        for (int i = 0; i < 300; i++) begin
            check("bad_reply", out_q[4+i], exp_q[i]);
        end
        check("wdt_not_fed_by_bad", 32'(wdt_expired), 32'd1);

        // Watchdog timing from a WRITE
        push_cmd(32'h1200_0001);
        wait_rd_en(20, "wdt_write_pop_timeout");
        @(posedge clk);
        #1;
        check("wdt_cleared_by_write", 32'(wdt_expired), 32'd0);
        repeat (99) @(posedge clk);
        #1;
        check("wdt_not_yet", 32'(wdt_expired), 32'd0);
        @(posedge clk);
        #1;
        check("wdt_expired_at_100", 32'(wdt_expired), 32'd1);
        tick(50);
        check("wdt_sticky", 32'(wdt_expired), 32'd1);

        // ECHO clears watchdog; status change while reply held goes out after it
        base = out_q.size();
        check("out_count_before_echo", 32'(base), 32'd304);
        @(negedge clk);
        tx_full = 1'b1;
        push_cmd(32'h3000_00AA);
        wait_rd_en(20, "echo2_pop_timeout");
        @(posedge clk);
        #1;
        check("wdt_cleared_by_echo", 32'(wdt_expired), 32'd0);
        status_in = 13'h1555;
        tick(5);
        check("echo2_held", 32'(out_q.size()), 32'(base));
        @(negedge clk);
        tx_full = 1'b0;
        wait_out(base + 2, 40, "echo2_release_timeout");
        check("echo2_reply",     out_q[base],   32'h3000_00AA);
        check("status_after_reply", out_q[base+1], 32'h0000_1555);
        tick(10);
        check("no_extra_words", 32'(out_q.size()), 32'(base + 2));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
